// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the 4-bit ALU execute stage.
//   - Command mode encodings (MODE_LDA..MODE_XCH); modes 5-7 are illegal.
//   - Execute FSM state encoding.
//   - Flag bit positions within the 4-bit flags word ({C, Z, N, V}).
//   - cmd_legal(): acceptance-time legality check for a (mode, index) pair.
package alu_pkg;

   localparam int unsigned DataW   = 4;
   localparam int unsigned IdxW    = 4;
   localparam int unsigned ModeW   = 3;
   localparam int unsigned NumRegs = 8;
   localparam int unsigned RegAW   = 3;

   localparam logic [ModeW-1:0] MODE_LDA = 3'd0;
   localparam logic [ModeW-1:0] MODE_ADD = 3'd1;
   localparam logic [ModeW-1:0] MODE_SUB = 3'd2;
   localparam logic [ModeW-1:0] MODE_STA = 3'd3;
   localparam logic [ModeW-1:0] MODE_XCH = 3'd4;

   localparam int unsigned FLAG_C = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_V = 0;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRead = 2'd1,
      StExec = 2'd2,
      StWb   = 2'd3
   } state_e;

   // Legal when the mode is one of the five defined commands and the index
   // addresses one of the eight registers (upper index bit clear).
   function automatic logic cmd_legal(input logic [ModeW-1:0] mode,
                                      input logic [IdxW-1:0]  idx);
      return (mode <= MODE_XCH) && (idx[IdxW-1] == 1'b0);
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 8 x 4-bit register file, cleared by synchronous reset.
//   clk_i      - clock
//   rst_i      - synchronous active-high reset, clears all registers
//   we_i       - write enable
//   waddr_i    - write address
//   wdata_i    - write data
//   raddr_a_i  - execution read address,  rdata_a_o - execution read data
//   raddr_b_i  - debug read address,      rdata_b_o - debug read data
// Both read ports are combinational; a write is visible the cycle after.
module alu_regfile
   import alu_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             we_i,
   input  logic [RegAW-1:0] waddr_i,
   input  logic [DataW-1:0] wdata_i,
   input  logic [RegAW-1:0] raddr_a_i,
   output logic [DataW-1:0] rdata_a_o,
   input  logic [RegAW-1:0] raddr_b_i,
   output logic [DataW-1:0] rdata_b_o
);

   logic [DataW-1:0] regs_q [NumRegs];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NumRegs; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = regs_q[raddr_a_i];
   assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/alu_executor.sv
// alu_executor: execute stage of the 4-bit ALU datapath.
// Every level change on toggle_in is one command (LDA/ADD/SUB/STA/XCH) run
// through IDLE -> READ -> EXEC -> WB against the accumulator, flags and an
// 8 x 4-bit register file. A one-deep pending slot absorbs a command that
// arrives while busy; a further command while the slot is full is dropped
// and sets the sticky overrun flag.
//   clk        - clock;  rst - synchronous active-high reset
//   toggle_in  - command strobe (any level change)
//   mode_in    - command mode;  index_in - register index;  acc_in - LDA immediate
//   acc_out    - accumulator;   flags - {C, Z, N, V}
//   busy       - command in READ/EXEC/WB
//   done       - one-cycle pulse after a committed command
//   illegal    - one-cycle pulse when an illegal command is dropped
//   overrun    - sticky, command lost because the pending slot was full
//   dbg_sel    - debug register select;  dbg_data - combinational register read
module alu_executor
   import alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             toggle_in,
   input  logic [ModeW-1:0] mode_in,
   input  logic [IdxW-1:0]  index_in,
   input  logic [DataW-1:0] acc_in,
   output logic [DataW-1:0] acc_out,
   output logic [3:0]       flags,
   output logic             busy,
   output logic             done,
   output logic             illegal,
   output logic             overrun,
   input  logic [RegAW-1:0] dbg_sel,
   output logic [DataW-1:0] dbg_data
);

   state_e state_q, state_d;

   logic tog_q;
   logic tog_edge;

   logic             pend_vld_q,  pend_vld_d;
   logic [ModeW-1:0] pend_mode_q, pend_mode_d;
   logic [IdxW-1:0]  pend_idx_q,  pend_idx_d;
   logic [DataW-1:0] pend_imm_q,  pend_imm_d;

   logic [ModeW-1:0] cmd_mode_q, cmd_mode_d;
   logic [RegAW-1:0] cmd_idx_q,  cmd_idx_d;
   logic [DataW-1:0] cmd_imm_q,  cmd_imm_d;

   logic [DataW-1:0] opnd_q,      opnd_d;
   logic [DataW-1:0] res_acc_q,   res_acc_d;
   logic [3:0]       res_flags_q, res_flags_d;

   logic [DataW-1:0] acc_q,   acc_d;
   logic [3:0]       flags_q, flags_d;
   logic             done_q,    done_d;
   logic             illegal_q, illegal_d;
   logic             overrun_q, overrun_d;

   logic             rf_we;
   logic [DataW-1:0] rf_wdata;
   logic [DataW-1:0] rf_rdata;

   logic [ModeW-1:0] src_mode;
   logic [IdxW-1:0]  src_idx;
   logic [DataW-1:0] src_imm;
   logic [DataW:0]   sum5;
   logic [DataW:0]   diff5;

   assign tog_edge = toggle_in ^ tog_q;

   // The pending slot has priority over a fresh edge when launching from IDLE.
   assign src_mode = pend_vld_q ? pend_mode_q : mode_in;
   assign src_idx  = pend_vld_q ? pend_idx_q  : index_in;
   assign src_imm  = pend_vld_q ? pend_imm_q  : acc_in;

   // 5-bit views: bit 4 of sum5 is the carry, bit 4 of diff5 the borrow.
   assign sum5  = {1'b0, acc_q} + {1'b0, opnd_q};
   assign diff5 = {1'b0, acc_q} - {1'b0, opnd_q};

   alu_regfile u_regfile (
      .clk_i     (clk),
      .rst_i     (rst),
      .we_i      (rf_we),
      .waddr_i   (cmd_idx_q),
      .wdata_i   (rf_wdata),
      .raddr_a_i (cmd_idx_q),
      .rdata_a_o (rf_rdata),
      .raddr_b_i (dbg_sel),
      .rdata_b_o (dbg_data)
   );

   always_comb begin
      state_d     = state_q;
      pend_vld_d  = pend_vld_q;
      pend_mode_d = pend_mode_q;
      pend_idx_d  = pend_idx_q;
      pend_imm_d  = pend_imm_q;
      cmd_mode_d  = cmd_mode_q;
      cmd_idx_d   = cmd_idx_q;
      cmd_imm_d   = cmd_imm_q;
      opnd_d      = opnd_q;
      res_acc_d   = res_acc_q;
      res_flags_d = res_flags_q;
      acc_d       = acc_q;
      flags_d     = flags_q;
      done_d      = 1'b0;
      illegal_d   = 1'b0;
      overrun_d   = overrun_q;
      rf_we       = 1'b0;
      rf_wdata    = acc_q;

      unique case (state_q)
         StIdle: begin
            if (pend_vld_q || tog_edge) begin
               if (cmd_legal(src_mode, src_idx)) begin
                  cmd_mode_d = src_mode;
                  cmd_idx_d  = src_idx[RegAW-1:0];
                  cmd_imm_d  = src_imm;
                  state_d    = StRead;
               end else begin
                  illegal_d = 1'b1;
               end
               pend_vld_d = 1'b0;
            end
         end
         StRead: begin
            opnd_d  = rf_rdata;
            state_d = StExec;
         end
         StExec: begin
            res_acc_d   = acc_q;
            res_flags_d = flags_q;
            case (cmd_mode_q)
               MODE_LDA: begin
                  res_acc_d   = cmd_imm_q;
                  res_flags_d = '0;
               end
               MODE_ADD: begin
                  res_acc_d           = sum5[DataW-1:0];
                  res_flags_d[FLAG_C] = sum5[DataW];
                  res_flags_d[FLAG_Z] = (sum5[DataW-1:0] == '0);
                  res_flags_d[FLAG_N] = sum5[DataW-1];
                  // Like-signed operands whose sum changes sign overflowed.
                  res_flags_d[FLAG_V] = (acc_q[DataW-1] == opnd_q[DataW-1]) &&
                                        (sum5[DataW-1] != acc_q[DataW-1]);
               end
               MODE_SUB: begin
                  res_acc_d           = diff5[DataW-1:0];
                  res_flags_d[FLAG_C] = diff5[DataW];
                  res_flags_d[FLAG_Z] = (diff5[DataW-1:0] == '0);
                  res_flags_d[FLAG_N] = diff5[DataW-1];
                  res_flags_d[FLAG_V] = (acc_q[DataW-1] != opnd_q[DataW-1]) &&
                                        (diff5[DataW-1] != acc_q[DataW-1]);
               end
               MODE_XCH: begin
                  res_acc_d           = opnd_q;
                  res_flags_d[FLAG_Z] = (opnd_q == '0);
                  res_flags_d[FLAG_N] = opnd_q[DataW-1];
               end
               default: ; // STA: accumulator and flags untouched
            endcase
            state_d = StWb;
         end
         StWb: begin
            acc_d   = res_acc_q;
            flags_d = res_flags_q;
            // STA and XCH both store the pre-commit accumulator.
            rf_we   = (cmd_mode_q == MODE_STA) || (cmd_mode_q == MODE_XCH);
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Edge capture into the pending slot. In IDLE the slot is only refilled
      // when it is being launched this same cycle; otherwise the edge itself
      // was consumed above.
      if (tog_edge) begin
         if (state_q == StIdle) begin
            if (pend_vld_q) begin
               pend_vld_d  = 1'b1;
               pend_mode_d = mode_in;
               pend_idx_d  = index_in;
               pend_imm_d  = acc_in;
            end
         end else if (!pend_vld_q) begin
            pend_vld_d  = 1'b1;
            pend_mode_d = mode_in;
            pend_idx_d  = index_in;
            pend_imm_d  = acc_in;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         tog_q       <= 1'b0;
         pend_vld_q  <= 1'b0;
         pend_mode_q <= '0;
         pend_idx_q  <= '0;
         pend_imm_q  <= '0;
         cmd_mode_q  <= '0;
         cmd_idx_q   <= '0;
         cmd_imm_q   <= '0;
         opnd_q      <= '0;
         res_acc_q   <= '0;
         res_flags_q <= '0;
         acc_q       <= '0;
         flags_q     <= '0;
         done_q      <= 1'b0;
         illegal_q   <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         tog_q       <= toggle_in;
         pend_vld_q  <= pend_vld_d;
         pend_mode_q <= pend_mode_d;
         pend_idx_q  <= pend_idx_d;
         pend_imm_q  <= pend_imm_d;
         cmd_mode_q  <= cmd_mode_d;
         cmd_idx_q   <= cmd_idx_d;
         cmd_imm_q   <= cmd_imm_d;
         opnd_q      <= opnd_d;
         res_acc_q   <= res_acc_d;
         res_flags_q <= res_flags_d;
         acc_q       <= acc_d;
         flags_q     <= flags_d;
         done_q      <= done_d;
         illegal_q   <= illegal_d;
         overrun_q   <= overrun_d;
      end
   end

   assign acc_out = acc_q;
   assign flags   = flags_q;
   assign busy    = (state_q != StIdle);
   assign done    = done_q;
   assign illegal = illegal_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_alu_executor.sv
// Self-checking bench for alu_executor: directed steps plus randomized
// commands checked against an arithmetic reference model of the accumulator,
// flags and register file.
module tb_alu_executor;

   logic       clk = 1'b0;
   logic       rst;
   logic       toggle_in;
   logic [2:0] mode_in;
   logic [3:0] index_in;
   logic [3:0] acc_in;
   logic [3:0] acc_out;
   logic [3:0] flags;
   logic       busy;
   logic       done;
   logic       illegal;
   logic       overrun;
   logic [2:0] dbg_sel;
   logic [3:0] dbg_data;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int m_acc;
   bit mc, mz, mn, mv;
   int m_regs[8];

   always #5 clk = ~clk;

   alu_executor dut (
      .clk       (clk),
      .rst       (rst),
      .toggle_in (toggle_in),
      .mode_in   (mode_in),
      .index_in  (index_in),
      .acc_in    (acc_in),
      .acc_out   (acc_out),
      .flags     (flags),
      .busy      (busy),
      .done      (done),
      .illegal   (illegal),
      .overrun   (overrun),
      .dbg_sel   (dbg_sel),
      .dbg_data  (dbg_data)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sgn4(input int x);
      return (x >= 8) ? x - 16 : x;
   endfunction

   function automatic logic [3:0] m_flags();
      return {mc, mz, mn, mv};
   endfunction

   task automatic model_reset();
      m_acc = 0;
      {mc, mz, mn, mv} = 4'b0;
      for (int i = 0; i < 8; i++) m_regs[i] = 0;
   endtask

   // Effect of one legal command on the architectural state.
   task automatic model_apply(input int mode, input int idx, input int imm);
      int r, s, t;
      r = m_regs[idx];
      case (mode)
         0: begin
            m_acc = imm;
            {mc, mz, mn, mv} = 4'b0;
         end
         1: begin
            s  = m_acc + r;
            t  = sgn4(m_acc) + sgn4(r);
            mc = (s > 15);
            mv = (t > 7) || (t < -8);
            m_acc = s % 16;
            mz = (m_acc == 0);
            mn = (m_acc >= 8);
         end
         2: begin
            s  = m_acc - r;
            t  = sgn4(m_acc) - sgn4(r);
            mc = (m_acc < r);
            mv = (t > 7) || (t < -8);
            m_acc = (s + 16) % 16;
            mz = (m_acc == 0);
            mn = (m_acc >= 8);
         end
         3: m_regs[idx] = m_acc;
         4: begin
            t = m_acc;
            m_acc = r;
            m_regs[idx] = t;
            mz = (m_acc == 0);
            mn = (m_acc >= 8);
         end
         default: ;
      endcase
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 8; i++) begin
         dbg_sel = 3'(i);
         #1;
         check(tag, dbg_data, m_regs[i]);
      end
   endtask

   // Issue one isolated command and follow it cycle by cycle to completion.
   task automatic run_cmd(input int mode, input int idx, input int imm);
      bit legal;
      int sel;
      legal = (mode < 5) && (idx < 8);
      @(negedge clk);
      mode_in   = 3'(mode);
      index_in  = 4'(idx);
      acc_in    = 4'(imm);
      toggle_in = ~toggle_in;
      @(negedge clk);
      if (legal) begin
         check("busy_n1", busy, 1);
         check("no_illegal_n1", illegal, 0);
      end else begin
         check("illegal_pulse_n1", illegal, 1);
         check("busy_illegal", busy, 0);
      end
      // Operands must have been captured in the edge cycle.
      mode_in  = 3'($urandom);
      index_in = 4'($urandom);
      acc_in   = 4'($urandom);
      for (int k = 2; k <= 4; k++) begin
         @(negedge clk);
         if (legal && k < 4) begin
            check("busy_mid", busy, 1);
            check("done_early", done, 0);
         end else if (!legal) begin
            check("illegal_once", illegal, 0);
            check("done_illegal", done, 0);
         end
      end
      if (legal) begin
         model_apply(mode, idx, imm);
         check("done_n4", done, 1);
         check("busy_n4", busy, 0);
      end
      check("acc", acc_out, m_acc);
      check("flags", flags, m_flags());
      sel = $urandom_range(0, 7);
      dbg_sel = 3'(sel);
      #1;
      check("dbg", dbg_data, m_regs[sel]);
      @(negedge clk);
      check("done_one_cycle", done, 0);
   endtask

   initial begin
      int c1_mode, c1_idx, c1_imm, c2_mode, c2_idx, c3_imm;
      int done_cnt, done_first, done_second;
      int md, ix;

      rst       = 1'b1;
      toggle_in = 1'b0;
      mode_in   = '0;
      index_in  = '0;
      acc_in    = '0;
      dbg_sel   = '0;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_acc", acc_out, 0);
      check("rst_flags", flags, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_illegal", illegal, 0);
      check("rst_overrun", overrun, 0);
      check_regs("rst_regs");

      // LDA
      run_cmd(0, 0, 5);
      check("lda_acc", acc_out, 4'h5);
      check("lda_flags", flags, 4'b0000);

      // STA / ADD / wrap
      run_cmd(3, 3, 0);
      run_cmd(0, 0, 9);
      run_cmd(1, 3, 0);
      check("add_acc", acc_out, 4'hE);
      check("add_flags", flags, 4'b0010);
      run_cmd(0, 0, 15);
      run_cmd(1, 3, 0);
      check("add_wrap_acc", acc_out, 4'h4);
      check("add_wrap_flags", flags, 4'b1000);

      // SUB
      run_cmd(0, 0, 5);
      run_cmd(2, 3, 0);
      check("sub_zero_acc", acc_out, 4'h0);
      check("sub_zero_flags", flags, 4'b0100);
      run_cmd(0, 0, 3);
      run_cmd(2, 3, 0);
      check("sub_borrow_acc", acc_out, 4'hE);
      check("sub_borrow_flags", flags, 4'b1010);
      run_cmd(0, 0, 8);
      run_cmd(2, 3, 0);
      check("sub_ovf_acc", acc_out, 4'h3);
      check("sub_ovf_flags", flags, 4'b0001);

      // XCH: acc=2 with C set, R1=7
      run_cmd(0, 0, 7);
      run_cmd(3, 1, 0);
      run_cmd(0, 0, 11);
      run_cmd(1, 1, 0);
      run_cmd(4, 1, 0);
      check("xch_acc", acc_out, 4'h7);
      check("xch_flags", flags, 4'b1000);
      dbg_sel = 3'd1;
      #1;
      check("xch_reg", dbg_data, 4'h2);

      // Illegal commands
      run_cmd(6, 2, 4);
      run_cmd(1, 9, 4);
      check_regs("illegal_regs");

      // Randomized commands
      for (int n = 0; n < 40; n++) begin
         md = $urandom_range(0, 4);
         ix = $urandom_range(0, 7);
         if ($urandom_range(0, 9) == 0) md = $urandom_range(5, 7);
         if ($urandom_range(0, 9) == 0) ix = $urandom_range(8, 15);
         run_cmd(md, ix, $urandom_range(0, 15));
      end
      check_regs("rand_regs");
      check("overrun_clear", overrun, 0);

      // Back-to-back: edges in cycles 0, 1, 2
      c1_mode = 0; c1_idx = 0; c1_imm = $urandom_range(0, 15);
      c2_mode = 1; c2_idx = $urandom_range(0, 7);
      model_apply(c1_mode, c1_idx, c1_imm);
      model_apply(c2_mode, c2_idx, 0);
      c3_imm = (m_acc + 1) % 16;
      @(negedge clk);
      mode_in = 3'(c1_mode); index_in = 4'(c1_idx); acc_in = 4'(c1_imm);
      toggle_in = ~toggle_in;
      @(negedge clk);
      mode_in = 3'(c2_mode); index_in = 4'(c2_idx); acc_in = 4'($urandom);
      toggle_in = ~toggle_in;
      @(negedge clk);
      mode_in = 3'd0; index_in = 4'd0; acc_in = 4'(c3_imm);
      toggle_in = ~toggle_in;
      done_cnt = 0; done_first = -1; done_second = -1;
      for (int cyc = 3; cyc <= 14; cyc++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            done_cnt++;
            if (done_first < 0) done_first = cyc;
            else if (done_second < 0) done_second = cyc;
         end
      end
      check("b2b_done_count", done_cnt, 2);
      check("b2b_done_first", done_first, 4);
      check("b2b_done_second", done_second, 8);
      check("b2b_overrun", overrun, 1);
      check("b2b_acc", acc_out, m_acc);
      check("b2b_flags", flags, m_flags());
      check_regs("b2b_regs");

      // Overrun is sticky
      run_cmd(0, 0, 9);
      run_cmd(3, 5, 0);
      check("overrun_sticky", overrun, 1);

      // Reset during EXEC of an ADD
      run_cmd(0, 0, 9);
      @(negedge clk);
      mode_in = 3'd1; index_in = 4'd5; acc_in = 4'd0;
      toggle_in = ~toggle_in;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      toggle_in = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check("mid_rst_acc", acc_out, 0);
      check("mid_rst_flags", flags, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_illegal", illegal, 0);
      check("mid_rst_overrun", overrun, 0);
      done_cnt = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(negedge clk);
         if (done === 1'b1) done_cnt++;
      end
      check("mid_rst_no_commit", done_cnt, 0);
      check("mid_rst_acc_hold", acc_out, 0);
      check_regs("mid_rst_regs");
      run_cmd(0, 0, 6);
      check("post_rst_lda", acc_out, 4'h6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
